// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Default geometry is four requesters, 8-bit bytes and four-byte bursts.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Width helper that never returns zero, so single-value fields stay legal.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int GID_W = bits_for(NREQ_DEF);
  localparam int CNT_W = bits_for(MAX_BURST_DEF + 1);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts one past the previous grantee, take the lowest set bit, rotate back.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic            found,
  output logic [GW-1:0]   winner
);

  logic [NREQ-1:0] rot;
  int              start;
  int              pos;

  always_comb begin
    start  = (int'(last_grant) + 1) % NREQ;
    rot    = (req >> start) | (req << (NREQ - start));
    found  = 1'b0;
    pos    = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    winner = GW'((start + pos) % NREQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte path between NREQ requesters,
// with per-grant bursts and a single registered output slot.
//
// state | meaning
// IDLE  | no grant; picker chooses the next requester after last_grant
// XFER  | requester grant_id owns the path until last, cap, or valid drop
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int GW = bits_for(NREQ);
  localparam int CW = bits_for(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              found;
  logic [GW-1:0]     winner;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              can_accept;
  logic              xfer;

  rr_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (found),
    .winner     (winner)
  );

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) g_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign g_valid    = req_valid[grant_q];
  assign g_last     = req_last[grant_q];
  // Slot is free when empty or being drained this cycle; never depends on req_valid.
  assign can_accept = !out_valid_q || out_ready;
  assign xfer       = (state_q == XFER) && g_valid && can_accept;

  always_comb begin
    req_ready = '0;
    if (state_q == XFER && can_accept) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (!g_valid) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (g_last || cnt_q == CW'(MAX_BURST - 1)) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A load in the same cycle as a drain overwrites the slot with no bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= g_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER) || out_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// message mixes scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  logic [8:0] src_q [NREQ][$];   // {last, byte} per requester
  logic [7:0] exp_q [$];
  int         acc_ids [$];
  int         acc_cyc [$];
  int         drain_cyc [$];
  int         acc_cnt [NREQ];
  logic [NREQ-1:0] vmask;
  int         ordy_mode;

  logic [NREQ-1:0] s_acc, s_rdy;
  logic            s_drain, s_ov;
  logic [7:0]      s_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (vmask[i] && src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = src_q[i][0][7:0];
        req_last[i]          = src_q[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    case (ordy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  // Sample on the falling edge, account for the handshakes after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    s_acc   = req_valid & req_ready;
    s_rdy   = req_ready;
    s_drain = out_valid & out_ready;
    s_ov    = out_valid;
    s_data  = out_data;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (s_ov) chk("busy_while_out_valid", 32'(busy), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (s_acc[i]) begin
        e = src_q[i].pop_front();
        acc_ids.push_back(i);
        acc_cyc.push_back(cyc);
        acc_cnt[i]++;
      end
    end
    if (s_drain) begin
      drain_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("exp_underflow", 32'(exp_q.size()), 1);
      else chk("out_data", 32'(s_data), 32'(exp_q.pop_front()));
    end
    drive();
  endtask

  function automatic int pending();
    int n = exp_q.size();
    for (int i = 0; i < NREQ; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic run_to_empty(input int budget);
    int n = 0;
    while ((pending() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drained", 32'(pending() + int'(out_valid)), 0);
  endtask

  // Reference: every loaded requester stays valid until its queue is empty, so
  // the byte order follows purely from round-robin over non-empty queues.
  task automatic build_expected();
    logic [8:0] m_q [NREQ][$];
    logic [8:0] e;
    int lg, w, n;
    for (int i = 0; i < NREQ; i++) m_q[i] = src_q[i];
    lg = NREQ - 1;
    while (1) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && m_q[(lg + k) % NREQ].size() > 0) w = (lg + k) % NREQ;
      end
      if (w < 0) break;
      n = 0;
      do begin
        e = m_q[w].pop_front();
        exp_q.push_back(e[7:0]);
        n++;
      end while (!e[8] && n < MB && m_q[w].size() > 0);
      lg = w;
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    exp_q.delete();
    acc_ids.delete();
    acc_cyc.delete();
    drain_cyc.delete();
    vmask     = '1;
    ordy_mode = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    drive();
  endtask

  initial begin
    int t0, n;
    vmask = '1;
    ordy_mode = 0;
    drive();
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_grant_id",  32'(grant_id), 0);

    // Single requester, two bytes, back to back.
    do_reset();
    load(0, 8'h41, 1'b0);
    load(0, 8'h42, 1'b1);
    build_expected();
    drive();
    t0 = cyc + 1;
    run_to_empty(50);
    chk("single_acc_cycle", 32'(acc_cyc.size() > 0 ? acc_cyc[0] - t0 : -1), 1);
    chk("single_drain0", 32'(drain_cyc.size() > 0 ? drain_cyc[0] - t0 : -1), 2);
    chk("single_drain1", 32'(drain_cyc.size() > 1 ? drain_cyc[1] - t0 : -1), 3);
    tick();
    chk("single_idle_ready", 32'(s_rdy), 0);
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_grant_id", 32'(grant_id), 0);

    // All four requesters, last on every byte.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) load(i, 8'((i << 4) | k), 1'b1);
    build_expected();
    drive();
    run_to_empty(100);
    chk("rr_count", 32'(acc_ids.size()), 8);
    for (int k = 0; k < acc_ids.size() && k < 8; k++) chk("rr_order", 32'(acc_ids[k]), 32'(k % NREQ));
    for (int k = 0; k + 1 < acc_cyc.size(); k++) chk("rr_gap", 32'(acc_cyc[k+1] - acc_cyc[k]), 2);

    // Burst cap: requester 2 streams six bytes, requester 3 waiting.
    do_reset();
    for (int k = 0; k < 6; k++) load(2, 8'(8'h10 + k), 1'b0);
    load(3, 8'h30, 1'b1);
    build_expected();
    drive();
    run_to_empty(100);
    chk("cap_count", 32'(acc_ids.size()), 7);
    if (acc_ids.size() == 7) begin
      chk("cap_id3", 32'(acc_ids[3]), 2);
      chk("cap_id4", 32'(acc_ids[4]), 3);
      chk("cap_id5", 32'(acc_ids[5]), 2);
    end

    // Backpressure: the first byte sits in the slot while out_ready is low.
    do_reset();
    load(0, 8'hA5, 1'b0);
    load(0, 8'hB6, 1'b1);
    build_expected();
    ordy_mode = 2;
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_ov && n < 10);
    chk("bp_loaded", 32'(s_ov), 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("bp_hold_data", 32'(s_data), 32'h A5);
      chk("bp_hold_valid", 32'(s_ov), 1);
      chk("bp_ready_low", 32'(s_rdy), 0);
    end
    ordy_mode = 0;
    drive();
    run_to_empty(50);

    // Valid drop mid-burst hands the path to the waiting requester.
    do_reset();
    load(1, 8'h51, 1'b0);
    load(1, 8'h52, 1'b0);
    load(1, 8'h53, 1'b0);
    load(1, 8'h54, 1'b1);
    load(2, 8'h61, 1'b1);
    exp_q = '{8'h51, 8'h52, 8'h61, 8'h53, 8'h54};
    drive();
    n = 0;
    while (acc_cnt[1] < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("drop_two_sent", 32'(acc_cnt[1]), 2);
    vmask[1] = 1'b0;
    drive();
    tick();
    chk("drop_no_move", 32'(s_acc), 0);
    tick();
    chk("drop_idle_ready", 32'(s_rdy), 0);
    tick();
    chk("drop_next_grant", 32'(s_rdy), 32'b0100);
    vmask[1] = 1'b1;
    drive();
    run_to_empty(50);

    // Asynchronous reset mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) load(0, 8'(8'h71 + k), k == 3);
    build_expected();
    drive();
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_ov && n < 10);
    @(negedge clk);
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data",  32'(out_data), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_busy",      32'(busy), 0);
    chk("arst_grant_id",  32'(grant_id), 0);
    do_reset();
    load(1, 8'h81, 1'b1);
    load(0, 8'h91, 1'b1);
    build_expected();
    drive();
    run_to_empty(50);
    chk("arst_first_grant", 32'(acc_ids.size() > 0 ? acc_ids[0] : -1), 0);

    // Randomized message mixes with random UART backpressure.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(0, 9);
        for (int k = 0; k < n; k++) load(i, 8'((i << 6) | (k & 63)), $urandom_range(0, 3) == 0);
      end
      build_expected();
      ordy_mode = 1;
      drive();
      run_to_empty(800);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path between `NREQ` byte-stream requesters. Each requester presents bytes on its own valid/ready channel. The arbiter grants one requester at a time for a burst, ending on `last` or at `MAX_BURST` bytes. Granted bytes pass through a one-entry registered output stage that drives the byte-buffer/UART TX input (`data_i`/`valid_in`/`ready_in`).

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `MAX_BURST`, 4: maximum bytes per grant, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  NREQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NREQ  marks the final byte of the requester's message; sampled with its byte.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `out_valid`  out  1  byte available to the UART TX input.
- `out_data`  out  DATA_W  byte to transmit.
- `out_ready`  in  1  UART-side accept; tied to the buffer's `ready_in`.
- `grant_id`  out  clog2(NREQ)  index of the current or most recent grantee.
- `busy`  out  1  high while in XFER or while `out_valid` is high.

## Operation
- FSM states:
  - IDLE: no grant.
  - XFER: the requester at `grant_id` is granted.
- Arbitration, IDLE only:
  - Search starts at `(last_grant+1) mod NREQ` and takes the first set `req_valid`.
  - If one is found: `grant_id` ← winner, `cnt` ← 0, go to XFER.
  - If none is found: stay in IDLE.
- Acceptance, XFER only:
  - `req_ready[grant_id] = !out_valid || out_ready`. All other `req_ready` bits are 0.
  - In IDLE, all `req_ready` bits are 0.
- Transfer: occurs when `req_valid[g] && req_ready[g]`.
  - `out_data` ← byte, `out_valid` ← 1, `cnt` ← `cnt+1`.
- Release conditions, XFER → IDLE with `last_grant` ← `grant_id`:
  - a transfer with `req_last[g]=1`; or
  - a transfer with `cnt == MAX_BURST-1`; or
  - `req_valid[g]=0` in any XFER cycle. No byte moves that cycle.
- Output stage:
  - `out_valid` clears on `out_ready` unless a new byte loads in the same cycle.
  - Simultaneous drain and load: new byte replaces old and `out_valid` stays 1. No bubble.
- `out_data` is held stable while `out_valid && !out_ready`.
- `cnt` width is clog2(MAX_BURST+1). It never wraps, because release always happens at `MAX_BURST-1`.
- A requester whose burst was cut by `MAX_BURST` re-arbitrates normally. Its `last` byte is not yet sent.

## Timing
- Reset values:
  - FSM = IDLE, `cnt`=0, `last_grant`=NREQ-1 (requester 0 wins first).
  - Outputs: `grant_id`=0, `out_valid`=0, `out_data`=0, `req_ready`=0, `busy`=0.
- Arbitration costs 1 cycle: `req_valid` rising in cycle N (FSM in IDLE) → XFER in N+1 → `req_ready` high in N+1.
- First byte is accepted in N+1; `out_valid` is high in N+2.
- Steady-state throughput is 1 byte/cycle while `out_ready` stays high.
- There is exactly one IDLE cycle between consecutive grants.
- `req_ready` is combinational from FSM state, `out_valid` and `out_ready`. There is no combinational path from `req_valid` to `req_ready`.
- Reset mid-burst: state and outputs clear immediately (asynchronous). An in-flight `out_data` byte is lost, not replayed.
- Requester dropping `req_valid` mid-burst without `last`: grant released the same cycle. That requester may win again only after the others in round-robin order.

## Structure
- Package `uart_arb_pkg`:
  - state enum {IDLE, XFER};
  - localparams `GID_W = clog2(NREQ)` and `CNT_W = clog2(MAX_BURST+1)`.
- Sub-module `rr_picker` (combinational): inputs `req` vector and `last_grant`; outputs `found` and `winner` index. Implemented as rotate, priority-encode, un-rotate.
- Top level holds:
  - FSM;
  - burst counter;
  - `last_grant` register;
  - one-entry output register;
  - `req_ready` decode.

## Test plan
- Single requester: req 0 sends 0x41, 0x42 with `last` on 0x42, `out_ready`=1.
  - `out_data` shows 0x41 then 0x42 on consecutive cycles.
  - FSM returns to IDLE; `last_grant`=0.
- All four requesters valid continuously, `last` on every byte:
  - grants go 0,1,2,3,0; one byte each;
  - one IDLE cycle between grants.
- Burst cap: req 2 streams 6 bytes 0x10..0x15 with no `last`, `MAX_BURST`=4, req 3 also valid:
  - 0x10..0x13 sent;
  - then req 3 is served;
  - then 0x14, 0x15 sent.
- Backpressure: `out_ready`=0 for 5 cycles after the first byte 0xA5:
  - `out_data` holds 0xA5;
  - `req_ready[g]`=0;
  - no byte lost; transfer resumes on `out_ready`=1.
- Valid drop: req 1 deasserts `req_valid` after 2 of 4 bytes:
  - XFER → IDLE next edge;
  - req 2 (pending) granted.
- Async reset asserted mid-burst with `out_valid`=1:
  - all outputs 0 immediately;
  - after release, requester 0 is granted first.
